// File: rtl/if_pc_redirect_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid port plus the valid/ready link to ID.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface if_pc_redirect_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        id_ready;

   modport master (
      output imem_req, imem_addr, if_valid, if_pc, if_inst,
      input  imem_gnt, imem_rvalid, imem_rdata, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_pc, if_inst,
      output imem_gnt, imem_rvalid, imem_rdata, id_ready
   );
endinterface

// File: rtl/if_pc_redirect.sv
// IF-stage PC generator: one-outstanding instruction fetch, small fetch queue to ID, EXE redirect handling.
// Define IF_MISALIGN_CHK_EN to trap misaligned redirect targets (if_misalign + HALT state).
module if_pc_redirect #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             JTYPE_FLUSH,
   input  logic [31:0]      JTYPE_REAL_ADDR,
   if_pc_redirect_if.master bus,
   output logic             if_misalign
);
   localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int CW = PW + 1;

`ifdef IF_MISALIGN_CHK_EN
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DROP, ST_HALT} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DROP} state_t;
`endif

   state_t          state_reg, state_next;
   logic [31:0]     pc_reg, pc_next;
   logic [31:0]     req_pc_reg;
   logic [31:0]     target;
   logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0]   cnt_reg;
   logic [31:0]     fq_pc   [FQ_DEPTH];
   logic [31:0]     fq_inst [FQ_DEPTH];
   logic            req, push, pop, empty;

`ifdef IF_MISALIGN_CHK_EN
   logic misalign_reg, misalign_next, target_misaligned;
   assign target            = JTYPE_REAL_ADDR;
   assign target_misaligned = |JTYPE_REAL_ADDR[1:0];
   assign if_misalign       = misalign_reg;
`else
   logic unused_addr_lsbs;
   assign target           = {JTYPE_REAL_ADDR[31:2], 2'b00};
   assign unused_addr_lsbs = |JTYPE_REAL_ADDR[1:0];
   assign if_misalign      = 1'b0;
`endif

   assign empty         = (cnt_reg == '0);
   assign bus.if_valid  = !empty && !JTYPE_FLUSH;
   assign pop           = bus.if_valid && bus.id_ready;
   assign bus.if_pc     = empty ? 32'h0 : fq_pc[rd_ptr_reg];
   assign bus.if_inst   = empty ? 32'h0 : fq_inst[rd_ptr_reg];
   assign bus.imem_req  = req;
   assign bus.imem_addr = pc_reg;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      req        = 1'b0;
      push       = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      misalign_next = misalign_reg;
`endif
      case (state_reg)
         ST_IDLE: state_next = ST_REQ;
         ST_REQ: begin
            // Only issue while a queue slot is free, so the response can always be pushed.
            req = !JTYPE_FLUSH && (cnt_reg < CW'(FQ_DEPTH));
            if (req && bus.imem_gnt) begin
               pc_next    = pc_reg + 32'd4;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.imem_rvalid) begin
               push       = !JTYPE_FLUSH;
               state_next = ST_REQ;
            end
         end
         ST_DROP: begin
            if (bus.imem_rvalid) begin
`ifdef IF_MISALIGN_CHK_EN
               state_next = misalign_reg ? ST_HALT : ST_REQ;
`else
               state_next = ST_REQ;
`endif
            end
         end
`ifdef IF_MISALIGN_CHK_EN
         ST_HALT: state_next = ST_HALT;
`endif
         default: state_next = ST_REQ;
      endcase

      // Redirect overrides everything decided above.
      if (JTYPE_FLUSH) begin
         pc_next = target;
         case (state_reg)
            ST_WAIT: state_next = bus.imem_rvalid ? ST_REQ : ST_DROP;
            ST_DROP: state_next = ST_DROP;
            default: state_next = ST_REQ;
         endcase
`ifdef IF_MISALIGN_CHK_EN
         misalign_next = target_misaligned;
         if (target_misaligned && state_next == ST_REQ) state_next = ST_HALT;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         pc_reg     <= RESET_PC;
         req_pc_reg <= 32'h0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         cnt_reg    <= '0;
`ifdef IF_MISALIGN_CHK_EN
         misalign_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
`ifdef IF_MISALIGN_CHK_EN
         misalign_reg <= misalign_next;
`endif
         if (req && bus.imem_gnt) req_pc_reg <= pc_reg;
         if (JTYPE_FLUSH) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            cnt_reg    <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            cnt_reg <= cnt_reg + CW'(push) - CW'(pop);
         end
      end
   end

   // Queue storage carries no reset; empty gating keeps the head outputs clean.
   always_ff @(posedge clk) begin
      if (push) begin
         fq_pc[wr_ptr_reg]   <= req_pc_reg;
         fq_inst[wr_ptr_reg] <= bus.imem_rdata;
      end
   end
endmodule

// File: tb/tb_if_pc_redirect.sv
// Bench for if_pc_redirect: random memory/ID/redirect stimulus, program-order reference model and scoreboard.
// Honours IF_MISALIGN_CHK_EN for the misaligned-target scenario.
module tb_if_pc_redirect;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          FQ_DEPTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] real_addr = 32'h0;
   logic        if_misalign;

   if_pc_redirect_if bus();

   if_pc_redirect #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .JTYPE_FLUSH     (flush),
      .JTYPE_REAL_ADDR (real_addr),
      .bus             (bus.master),
      .if_misalign     (if_misalign)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: expected program order, one pending memory transaction, epoch per redirect.
   ent_t        sbq[$];
   logic [31:0] exp_pc = RESET_PC;
   bit          pend_valid = 0;
   logic [31:0] pend_addr, pend_exp;
   int          pend_epoch, pend_delay;
   int          epoch = 0;
   int          fetches = 0, pops = 0;
   int          ready_pct = 100, gnt_pct = 100, lat_min = 1, lat_max = 1;
   bit          gnt_evt = 0, last_req = 0, saw_wrap = 0;
   logic [31:0] last_gnt = 32'h0, last_pop_pc = 32'h0;
   ent_t        mon_e;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // One clock of stimulus: drive at negedge, observe the issued request, advance the model.
   task automatic step(input logic fl, input logic [31:0] tgt);
      @(negedge clk);
      flush           = fl;
      real_addr       = tgt;
      bus.id_ready    = ($urandom_range(0, 99) < ready_pct);
      bus.imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
      bus.imem_rvalid = pend_valid && (pend_delay == 0);
      bus.imem_rdata  = bus.imem_rvalid ? inst_of(pend_addr) : $urandom;
      #1;
      gnt_evt  = 0;
      last_req = bus.imem_req;
      if (bus.imem_req) chk1("one_outstanding", pend_valid, 1'b0);
      if (bus.imem_rvalid) begin
         if (!fl && pend_epoch == epoch) sbq.push_back('{pc: pend_exp, inst: inst_of(pend_exp)});
         pend_valid = 0;
      end else if (pend_valid) begin
         pend_delay--;
      end
      if (bus.imem_req && bus.imem_gnt) begin
         chk("fetch_addr", bus.imem_addr, exp_pc);
         if (bus.imem_addr == 32'h0 && last_gnt == 32'hFFFF_FFFC) saw_wrap = 1;
         last_gnt   = bus.imem_addr;
         pend_valid = 1;
         pend_addr  = bus.imem_addr;
         pend_exp   = exp_pc;
         pend_epoch = epoch;
         pend_delay = int'($urandom_range(lat_min, lat_max)) - 1;
         exp_pc     = exp_pc + 32'd4;
         fetches++;
         gnt_evt = 1;
      end
      if (fl) begin
         sbq.delete();
         epoch++;
         exp_pc = tgt & 32'hFFFF_FFFC;
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      flush           = 1'b0;
      real_addr       = 32'h0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.id_ready    = 1'b0;
      repeat (2) @(negedge clk);
      pend_valid = 0;
      sbq.delete();
      epoch++;
      exp_pc   = RESET_PC;
      last_gnt = 32'h0;
      #1;
      chk1("reset_req", bus.imem_req, 1'b0);
      chk1("reset_valid", bus.if_valid, 1'b0);
      chk1("reset_misalign", if_misalign, 1'b0);
      chk("reset_if_pc", bus.if_pc, 32'h0);
      chk("reset_if_inst", bus.if_inst, 32'h0);
      @(negedge clk);
      rst             = 1'b0;
      bus.imem_rvalid = 1'b1;          // stray response right after reset must be ignored
      bus.imem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk1("idle_no_req", bus.imem_req, 1'b0);
      @(posedge clk);
   endtask

   task automatic run_until_gnt(input string name, input logic [31:0] exp_addr);
      int n = 0;
      do begin
         step(1'b0, 32'h0);
         n++;
      end while (!gnt_evt && n < 20);
      chk1({name, "_gnt_seen"}, gnt_evt, 1'b1);
      chk({name, "_gnt_addr"}, last_gnt, exp_addr);
   endtask

   // Monitor: pops the scoreboard whenever ID accepts an instruction.
   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         if (flush) chk1("valid_during_flush", bus.if_valid, 1'b0);
         if (bus.if_valid && bus.id_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_output: got pc %h inst %h, expected no entry", bus.if_pc, bus.if_inst);
            end else begin
               mon_e = sbq.pop_front();
               chk("if_pc", bus.if_pc, mon_e.pc);
               chk("if_inst", bus.if_inst, mon_e.inst);
            end
            pops++;
            last_pop_pc = bus.if_pc;
            $display("pop pc=%h inst=%h", bus.if_pc, bus.if_inst);
         end
      end
   end

   initial begin
      int p0, f0, n;
      do_reset();

      // Streaming at full rate
      ready_pct = 100; gnt_pct = 100; lat_min = 1; lat_max = 1;
      p0 = pops;
      repeat (21) step(1'b0, 32'h0);
      chk1("stream_pops", (pops - p0) >= 9, 1'b1);

      // Back-pressure: queue fills after FQ_DEPTH fetches, resumes at pc 8
      do_reset();
      ready_pct = 0;
      f0 = fetches;
      repeat (12) step(1'b0, 32'h0);
      chk("stall_fetches", 32'(fetches - f0), 32'd2);
      chk1("stall_req", last_req, 1'b0);
      ready_pct = 100;
      run_until_gnt("stall_resume", 32'h8);

      // Redirect latency from REQ with nothing outstanding
      n = 0;
      while (pend_valid && n < 10) begin step(1'b0, 32'h0); n++; end
      step(1'b1, 32'h300);
      p0 = pops;
      step(1'b0, 32'h0);
      chk1("lat_gnt", gnt_evt, 1'b1);
      chk("lat_gnt_addr", last_gnt, 32'h300);
      step(1'b0, 32'h0);
      chk("lat_no_early_valid", 32'(pops - p0), 32'd0);
      step(1'b0, 32'h0);
      chk("lat_pop_count", 32'(pops - p0), 32'd1);
      chk("lat_pop_pc", last_pop_pc, 32'h300);

      // Redirect while a fetch is outstanding: old data dropped
      lat_min = 3; lat_max = 3;
      n = 0;
      while (!(pend_valid && pend_delay > 0) && n < 20) begin step(1'b0, 32'h0); n++; end
      p0 = pops;
      step(1'b1, 32'h100);
      run_until_gnt("flush_wait", 32'h100);
      chk("flush_wait_no_valid", 32'(pops - p0), 32'd0);

      // Redirect coinciding with rvalid while the queue holds an entry
      lat_min = 1; lat_max = 1; ready_pct = 0;
      n = 0;
      while (!(pend_valid && pend_delay == 0 && sbq.size() > 0) && n < 20) begin
         step(1'b0, 32'h0);
         n++;
      end
      ready_pct = 100;
      step(1'b1, 32'h200);
      run_until_gnt("flush_rv", 32'h200);
      p0 = pops;
      n = 0;
      while (pops == p0 && n < 10) begin step(1'b0, 32'h0); n++; end
      chk("flush_rv_first_pc", last_pop_pc, 32'h200);

      // PC wrap-around
      step(1'b1, 32'hFFFF_FFF8);
      repeat (10) step(1'b0, 32'h0);
      chk1("pc_wrap", saw_wrap, 1'b1);

      // Misaligned redirect target
`ifdef IF_MISALIGN_CHK_EN
      step(1'b1, 32'h102);
      #1;
      chk1("misalign_set", if_misalign, 1'b1);
      f0 = fetches;
      repeat (8) step(1'b0, 32'h0);
      chk("misalign_halt_fetches", 32'(fetches - f0), 32'd0);
      chk1("misalign_hold", if_misalign, 1'b1);
      step(1'b1, 32'h200);
      #1;
      chk1("misalign_clear", if_misalign, 1'b0);
      run_until_gnt("misalign_resume", 32'h200);
`else
      step(1'b1, 32'h102);
      run_until_gnt("misalign_forced", 32'h100);
      chk1("misalign_tied", if_misalign, 1'b0);
`endif

      // Randomized traffic with redirects and mid-run resets
      p0 = pops;
      for (int i = 0; i < 2000; i++) begin
         if (i % 100 == 0) begin
            ready_pct = $urandom_range(20, 100);
            gnt_pct   = $urandom_range(30, 100);
            lat_min   = $urandom_range(1, 2);
            lat_max   = lat_min + int'($urandom_range(0, 2));
         end
         if (i == 700 || i == 1400) do_reset();
         if ($urandom_range(0, 99) < 4)
            step(1'b1, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC));
         else
            step(1'b0, 32'h0);
      end
      chk1("random_progress", (pops - p0) > 100, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
